dmem_responder: RTL and testbench

- Data-memory responder serving the MEM-stage load/store requests issued by the pipelined MIPS core.
- It is the memory end of the core's data-access interface. Requests use a valid/ready handshake and are served after a programmable wait-state latency.
- It drives a stall line back to the pipeline hazard logic while an access is outstanding.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 42 ++++
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int ADDR_LSB = 2;
   localparam int CNT_W    = 4;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with registered read; byte enables when DMEM_BYTE_WRITE_EN is defined.
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_wdata,
`ifdef DMEM_BYTE_WRITE_EN
   input  logic [DATA_W/8-1:0] i_be,
`endif
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Contents survive reset; only the read register is cleared.
   always_ff @(posedge i_clk) begin
      if (i_en && i_we) begin
`ifdef DMEM_BYTE_WRITE_EN
         for (int b = 0; b < DATA_W/8; b++) begin
            if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
`else
         r_mem[i_idx] <= i_wdata;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)              r_rdata <= '0;
      else if (i_en && !i_we)    r_rdata <= r_mem[i_idx];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: valid/ready request, LATENCY wait states, stall to hazard unit.
// Optional byte-enable stores under DMEM_BYTE_WRITE_EN.
//  state | meaning
//  IDLE  | ready; accepts a request when i_req_valid
//  WAIT  | counting down wait states, pipeline stalled
//  RESP  | one-cycle response pulse
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
   input  logic [DATA_W/8-1:0] i_req_be,
`endif
   output logic              o_req_ready,
   output logic              o_resp_valid,
   output logic [DATA_W-1:0] o_resp_rdata,
   output logic              o_misalign_err,
   output logic              o_stall
);

   localparam int              IDX_W = idx_w(DEPTH);
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

   state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_write, r_mis;
   logic [IDX_W-1:0]    r_idx;
   logic [DATA_W-1:0]   r_wdata;

   logic                w_in_idle, w_accept, w_access, w_req_mis;
   logic                w_cur_write, w_cur_mis;
   logic [IDX_W-1:0]    w_req_idx, w_cur_idx;
   logic [DATA_W-1:0]   w_cur_wdata, w_arr_rdata;
   logic                w_unused;

   assign w_in_idle = (r_state == IDLE);
   assign w_accept  = w_in_idle && i_req_valid;
   assign w_req_idx = i_req_addr[ADDR_LSB +: IDX_W];
   assign w_req_mis = |i_req_addr[ADDR_LSB-1:0];
   assign w_unused  = ^i_req_addr[ADDR_W-1:ADDR_LSB+IDX_W];

   // With LATENCY=0 the array is accessed on the accept edge, before the latches hold the request.
   assign w_cur_write = w_in_idle ? i_req_write : r_write;
   assign w_cur_mis   = w_in_idle ? w_req_mis   : r_mis;
   assign w_cur_idx   = w_in_idle ? w_req_idx   : r_idx;
   assign w_cur_wdata = w_in_idle ? i_req_wdata : r_wdata;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_req_valid) w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
         WAIT:    if (r_cnt == CNT_W'(1)) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_access = (w_state_nxt == RESP) && (r_state != RESP) && i_rst_n;

`ifdef DMEM_BYTE_WRITE_EN
   logic [DATA_W/8-1:0] r_be, w_cur_be;
   assign w_cur_be = w_in_idle ? i_req_be : r_be;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      r_be <= '0;
      else if (w_accept) r_be <= i_req_be;
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_mis   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_write <= i_req_write;
            r_mis   <= w_req_mis;
            r_idx   <= w_req_idx;
            r_wdata <= i_req_wdata;
            r_cnt   <= LAT_C;
         end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_access),
      .i_we    (w_cur_write && !w_cur_mis),
      .i_idx   (w_cur_idx),
      .i_wdata (w_cur_wdata),
`ifdef DMEM_BYTE_WRITE_EN
      .i_be    (w_cur_be),
`endif
      .o_rdata (w_arr_rdata)
   );

   assign o_req_ready    = w_in_idle;
   assign o_stall        = w_accept || (r_state == WAIT);
   assign o_resp_valid   = (r_state == RESP);
   assign o_misalign_err = (r_state == RESP) && r_mis;
   assign o_resp_rdata   = ((r_state == RESP) && !r_write && !r_mis) ? w_arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0, checked against a word-array model.
module tb_dmem_responder;

`ifdef DMEM_BYTE_WRITE_EN
   localparam bit BE_EN = 1'b1;
`else
   localparam bit BE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_valid = 0, a_write = 0, b_valid = 0, b_write = 0;
   logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
   logic [3:0]  a_be = 4'hF, b_be = 4'hF;
   logic        a_ready, a_rv, a_mis, a_stall, b_ready, b_rv, b_mis, b_stall;
   logic [31:0] a_rdata, b_rdata;

   dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(a_valid), .i_req_write(a_write),
      .i_req_addr(a_addr), .i_req_wdata(a_wdata),
`ifdef DMEM_BYTE_WRITE_EN
      .i_req_be(a_be),
`endif
      .o_req_ready(a_ready), .o_resp_valid(a_rv), .o_resp_rdata(a_rdata),
      .o_misalign_err(a_mis), .o_stall(a_stall));

   dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(0)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(b_valid), .i_req_write(b_write),
      .i_req_addr(b_addr), .i_req_wdata(b_wdata),
`ifdef DMEM_BYTE_WRITE_EN
      .i_req_be(b_be),
`endif
      .o_req_ready(b_ready), .o_resp_valid(b_rv), .o_resp_rdata(b_rdata),
      .o_misalign_err(b_mis), .o_stall(b_stall));

   int total = 0;
   int bad   = 0;

   logic [31:0] ref_a [int];
   logic [31:0] ref_b [int];

   logic        s_ready, s_rv, s_mis, s_stall;
   logic [31:0] s_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic snap(input int sel);
      if (sel == 0) begin
         s_ready = a_ready; s_rv = a_rv; s_mis = a_mis; s_stall = a_stall; s_rdata = a_rdata;
      end else begin
         s_ready = b_ready; s_rv = b_rv; s_mis = b_mis; s_stall = b_stall; s_rdata = b_rdata;
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (!BE_EN || be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      end
      return r;
   endfunction

   task automatic drive(input int sel, input logic v, input logic w, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [3:0] be);
      if (sel == 0) begin a_valid = v; a_write = w; a_addr = ad; a_wdata = wd; a_be = be; end
      else          begin b_valid = v; b_write = w; b_addr = ad; b_wdata = wd; b_be = be; end
   endtask

   task automatic access(input int sel, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input bit scramble,
                         input string tag);
      int          lat, idx, n;
      bit          mis, got;
      logic [31:0] exp_rd, old;
      lat = (sel == 0) ? 2 : 0;
      idx = int'((addr / 4) % 256);
      mis = (addr % 4) != 0;
      if (sel == 0) old = ref_a.exists(idx) ? ref_a[idx] : 32'h0;
      else          old = ref_b.exists(idx) ? ref_b[idx] : 32'h0;
      exp_rd = (wr || mis) ? 32'h0 : old;

      @(negedge clk);
      drive(sel, 1'b1, wr, addr, wdata, be);
      #1 snap(sel);
      chk({tag, "_ready"}, 32'(s_ready), 32'd1);
      chk({tag, "_stall_acc"}, 32'(s_stall), 32'd1);

      n = 0; got = 0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         snap(sel);
         if (s_rv) got = 1;
         else begin
            chk({tag, "_stall_wait"}, 32'(s_stall), 32'd1);
            if (scramble && n == 1)
               drive(sel, 1'b0, $urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
         end
      end
      chk({tag, "_got_resp"}, 32'(got), 32'd1);
      if (got) begin
         chk({tag, "_latency"}, 32'(n), 32'(lat + 1));
         chk({tag, "_rdata"}, s_rdata, exp_rd);
         chk({tag, "_mis"}, 32'(s_mis), 32'(mis));
         chk({tag, "_stall_resp"}, 32'(s_stall), 32'd0);
      end
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
      if (wr && !mis) begin
         if (sel == 0) ref_a[idx] = merge(old, wdata, be);
         else          ref_b[idx] = merge(old, wdata, be);
      end
      @(negedge clk);
      snap(sel);
      chk({tag, "_idle_rv"}, 32'(s_rv), 32'd0);
      chk({tag, "_idle_ready"}, 32'(s_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] ad;
      int          sel, idx;
      #12;
      for (int s = 0; s < 2; s++) begin
         snap(s);
         chk("rst_ready", 32'(s_ready), 32'd1);
         chk("rst_stall", 32'(s_stall), 32'd0);
         chk("rst_rv", 32'(s_rv), 32'd0);
         chk("rst_rdata", s_rdata, 32'd0);
         chk("rst_mis", 32'(s_mis), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      snap(0);
      chk("post_rst_ready", 32'(s_ready), 32'd1);
      chk("post_rst_stall", 32'(s_stall), 32'd0);

      for (int i = 0; i < 16; i++) begin
         access(0, 1'b1, i * 4, $urandom, 4'hF, 1'b0, "init_a");
         access(1, 1'b1, i * 4, $urandom, 4'hF, 1'b0, "init_b");
      end

      access(0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, "st10");
      access(0, 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, "ld10");
      access(0, 1'b1, 32'h400, 32'h11111111, 4'hF, 1'b0, "st400");
      access(0, 1'b0, 32'h000, 32'h0,        4'hF, 1'b0, "ld000_alias");
      access(0, 1'b1, 32'h13,  32'h5A5A5A5A, 4'hF, 1'b0, "st13_mis");
      access(0, 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, "ld10_after_mis");
      access(0, 1'b0, 32'h12,  32'h0,        4'hF, 1'b0, "ld12_mis");

      // Abort a store while in WAIT by pulsing reset.
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
      @(negedge clk);
      snap(0);
      chk("abort_in_wait_stall", 32'(s_stall), 32'd1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
      rst_n = 1'b0;
      #1 snap(0);
      chk("abort_rv", 32'(s_rv), 32'd0);
      chk("abort_ready", 32'(s_ready), 32'd1);
      chk("abort_stall", 32'(s_stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      snap(0);
      chk("abort_no_late_resp", 32'(s_rv), 32'd0);
      access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, "ld20_after_abort");

      access(1, 1'b1, 32'h0, 32'h00000000, 4'hF, 1'b0, "b_clear0");
      access(1, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 1'b0, "b_st_be");
      access(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, "b_ld_be");
      access(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'b0000, 1'b0, "b_st_be0");
      access(1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, "b_ld_be0");

      for (int k = 0; k < 60; k++) begin
         sel = $urandom_range(0, 1);
         idx = $urandom_range(0, 15);
         ad  = {$urandom_range(0, 4194303), 10'h0} | (idx * 4);
         if ($urandom_range(0, 7) == 0) ad[1:0] = 2'($urandom_range(1, 3));
         access(sel, 1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom),
                1'(sel == 0 && $urandom_range(0, 1) == 1), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
